// File: rtl/mipi_pixel_packer.sv
// mipi_pixel_packer: packs 8-bit grey pixels into little-endian 32-bit frame RAM writes.
// Optional feature macro: PACKER_FREEZE_EN adds freeze_i and the FROZEN state.
module mipi_pixel_packer #(
    parameter int WORDS  = 76800,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_start_i,
    input  logic [7:0]        pixel_i,
    input  logic              pixel_valid_i,
`ifdef PACKER_FREEZE_EN
    input  logic              freeze_i,
`endif
    output logic [31:0]       data_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              we_o,
    output logic              frame_done_o,
    output logic              frame_short_o,
    output logic              busy_o,
    output logic [7:0]        frame_count_o
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);
`ifdef PACKER_FREEZE_EN
    typedef enum logic [1:0] {IDLE, ACTIVE, FULL, FROZEN} state_t;
    state_t start_state;
    assign start_state = freeze_i ? FROZEN : ACTIVE;
`else
    typedef enum logic [1:0] {IDLE, ACTIVE, FULL} state_t;
    state_t start_state;
    assign start_state = ACTIVE;
`endif
    state_t            state_q;
    logic [23:0]       sr_q;
    logic [1:0]        byte_cnt_q;
    logic [ADDR_W-1:0] word_cnt_q;
    logic [31:0]       data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q, done_q, short_q;
    logic [7:0]        count_q;
    logic              take_first;
    assign take_first = pixel_valid_i && start_state == ACTIVE;
    // frame FSM: frame_start always wins and restarts the frame; pixels are packed only in ACTIVE
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            short_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            we_q    <= 1'b0;
            done_q  <= 1'b0;
            short_q <= 1'b0;
            if (frame_start_i) begin
                short_q    <= state_q == ACTIVE && (word_cnt_q != '0 || byte_cnt_q != '0);
                state_q    <= start_state;
                word_cnt_q <= '0;
                byte_cnt_q <= {1'b0, take_first};
                if (take_first) sr_q <= {pixel_i, sr_q[23:8]};
            end else if (state_q == ACTIVE && pixel_valid_i) begin
                sr_q       <= {pixel_i, sr_q[23:8]};
                byte_cnt_q <= byte_cnt_q + 2'd1;
                if (byte_cnt_q == 2'd3) begin
                    data_q     <= {pixel_i, sr_q};
                    addr_q     <= word_cnt_q;
                    we_q       <= 1'b1;
                    word_cnt_q <= word_cnt_q == LAST ? '0 : word_cnt_q + ADDR_W'(1);
                    if (word_cnt_q == LAST) begin
                        done_q  <= 1'b1;
                        count_q <= count_q + 8'd1;
                        state_q <= FULL;
                    end
                end
            end
        end
    end
    assign data_o        = data_q;
    assign addr_o        = addr_q;
    assign we_o          = we_q;
    assign frame_done_o  = done_q;
    assign frame_short_o = short_q;
    assign busy_o        = state_q == ACTIVE;
    assign frame_count_o = count_q;
endmodule
